// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Consumer-side bundle of the UART receiver (byte, handshake and
//               status flags).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  modport master (
    input  rx_read,
    output rx_data, rx_valid, overrun, frame_err, parity_err, busy
  );

  modport slave (
    output rx_read,
    input  rx_data, rx_valid, overrun, frame_err, parity_err, busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_rx_oversample.sv
// ============================================================================
// Module      : uart_rx_oversample
// Description : 16x oversampling UART receiver, 3-sample majority vote,
//               framing/overrun detection. Define UART_RX_PARITY_EN for 8P1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_oversample #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     rxd,
  uart_rx_if.master bus
);

  localparam int             DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int             CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_HIGH = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic          meta_q, rs_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    s_q, s_d;
  logic [1:0]    samp_q, samp_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          perr_q, perr_d;
  logic          par_bad_q, par_bad_d;
`endif

  logic          tick, decide, vote, complete;
  logic [3:0]    s_next;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_d      = s_q;
    samp_d   = samp_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    ferr_d   = 1'b0;
    complete = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d    = 1'b0;
    par_bad_d = par_bad_q;
`endif

    tick   = (cnt_q == DIV_M1);
    s_next = s_q + 4'd1;
    // The decision tick is the one that advances s to 9; samples 7 and 8
    // were latched on the two ticks before it.
    decide = tick && (s_next == 4'd9);
    vote   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rs_q) | (samp_q[1] & rs_q);

    if (state_q != S_IDLE) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        s_d = s_next;
        if (s_next == 4'd7) samp_d[0] = rs_q;
        if (s_next == 4'd8) samp_d[1] = rs_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        s_d   = 4'd0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rs_q) state_d = S_START;
      end
      S_START: begin
        if (decide) begin
          state_d = vote ? S_IDLE : S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_d = {vote, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (decide) begin
          par_bad_d = (vote != ((^shift_q) ^ PARITY_ODD));
          perr_d    = par_bad_d;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (decide) begin
          if (vote) begin
`ifdef UART_RX_PARITY_EN
            complete = !par_bad_q;
`else
            complete = 1'b1;
`endif
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        if (rs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A pending unread byte wins over a new one unless it is read this cycle.
    if (complete) begin
      if (valid_q && !bus.rx_read) begin
        ovr_d = 1'b1;
      end else begin
        data_d  = shift_q;
        valid_d = 1'b1;
        if (bus.rx_read) ovr_d = 1'b0;
      end
    end else if (bus.rx_read && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      meta_q  <= 1'b1;
      rs_q    <= 1'b1;
      cnt_q   <= '0;
      s_q     <= 4'd0;
      samp_q  <= 2'b00;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q    <= 1'b0;
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      meta_q  <= rxd;
      rs_q    <= meta_q;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q    <= perr_d;
      par_bad_q <= par_bad_d;
`endif
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.overrun   = ovr_q;
  assign bus.frame_err = ferr_q;
  assign bus.busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
